// File: rtl/cmd_reply_packer_if.sv
// cmd_reply_packer_if
//   Groups the two streaming sides of the command reply packer.
//   Reply side : rx_databus / rx_WR / rx_WR_done from the command reader,
//                rx_WR_enabled back to it.
//   FIFO side  : fifo_data / fifo_wrreq toward the RX packet FIFO,
//                fifo_full (almost-full) back from it.
//   slave  modport : the packer's view.
//   master modport : the surrounding logic (command reader + FIFO) view.
interface cmd_reply_packer_if;
    logic [15:0] rx_databus;
    logic        rx_WR;
    logic        rx_WR_done;
    logic        rx_WR_enabled;
    logic [15:0] fifo_data;
    logic        fifo_wrreq;
    logic        fifo_full;

    modport master (
        output rx_databus, rx_WR, rx_WR_done, fifo_full,
        input  rx_WR_enabled, fifo_data, fifo_wrreq
    );

    modport slave (
        input  rx_databus, rx_WR, rx_WR_done, fifo_full,
        output rx_WR_enabled, fifo_data, fifo_wrreq
    );
endinterface

// File: rtl/cmd_reply_packer.sv
// cmd_reply_packer
//   Collects 16-bit reply words from the command reader and frames them into
//   fixed-size inband packets on the command channel: 2 header words,
//   2 timestamp words, the buffered payload, then zero padding up to
//   PKT_WORDS. Each packet is written word-by-word into the RX packet FIFO.
//   A packet is flushed when the payload buffer is full, or when it holds at
//   least one word and the command reader has been idle (rx_WR_done high, no
//   rx_WR) for IDLE_TIMEOUT cycles.
// Ports
//   txclk           clock
//   reset           synchronous, active-high
//   timestamp_clock free-running timestamp, latched at flush time
//   bus             reply-side and FIFO-side signals (slave modport)
//   dropped_words   saturating count of rejected reply words
//   busy            high while a packet is being emitted
module cmd_reply_packer #(
    parameter int         PKT_WORDS    = 256,
    parameter int         HDR_WORDS    = 4,
    parameter int         IDLE_TIMEOUT = 16,
    parameter logic [4:0] CHAN         = 5'h1F
) (
    input  logic                 txclk,
    input  logic                 reset,
    input  logic [31:0]          timestamp_clock,
    cmd_reply_packer_if.slave    bus,
    output logic [7:0]           dropped_words,
    output logic                 busy
);
    localparam int PAYLOAD_WORDS = PKT_WORDS - HDR_WORDS;
    localparam int IDLE_W        = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [7:0]        PAYLOAD_MAX = 8'(PAYLOAD_WORDS);
    localparam logic [7:0]        ENABLE_MAX  = 8'(PAYLOAD_WORDS - 2);
    localparam logic [7:0]        LAST_W      = 8'(PKT_WORDS - 1);
    localparam logic [7:0]        HDR_W       = 8'(HDR_WORDS);
    localparam logic [IDLE_W-1:0] IDLE_MAX    = IDLE_W'(IDLE_TIMEOUT);

    typedef enum logic {
        FILL,
        EMIT
    } state_t;

    state_t state, next_state;

    logic [15:0]       payload_buf [PAYLOAD_WORDS];
    logic [7:0]        count;
    logic [IDLE_W-1:0] idle_cnt;
    logic [7:0]        w_idx;
    logic [7:0]        payload_idx;
    logic [9:0]        len_bytes;
    logic [31:0]       ts;
    logic [15:0]       emit_word;
    logic              accept;
    logic              drop;
    logic              wr_d;
    logic [15:0]       data_d;

    // A word is taken only while filling and there is room; anything else
    // that arrives on rx_WR is counted as dropped.
    assign accept      = (state == FILL) && bus.rx_WR && (count < PAYLOAD_MAX);
    assign drop        = bus.rx_WR && !accept;
    assign payload_idx = w_idx - HDR_W;

    // State register.
    always_ff @(posedge txclk) begin
        if (reset) state <= FILL;
        else       state <= next_state;
    end

    // Next-state logic and the value to present to the FIFO next cycle.
    // A timeout flush is held off when a word arrives in the same cycle so
    // that word is not silently lost from the latched length.
    always_comb begin
        next_state = state;
        wr_d       = 1'b0;
        data_d     = '0;
        unique case (state)
            FILL: begin
                if ((count == PAYLOAD_MAX) ||
                    ((count != 8'd0) && (idle_cnt == IDLE_MAX) && !bus.rx_WR))
                    next_state = EMIT;
            end
            EMIT: begin
                if (!bus.fifo_full) begin
                    wr_d   = 1'b1;
                    data_d = emit_word;
                    if (w_idx == LAST_W) next_state = FILL;
                end
            end
            default: next_state = FILL;
        endcase
    end

    // Packet word for the current index: length, flags/channel, timestamp,
    // buffered payload, then zero padding.
    always_comb begin
        emit_word = '0;
        case (w_idx)
            8'd0: emit_word = {6'd0, len_bytes};
            8'd1: emit_word = {4'b0000, 1'b1, 1'b1, 2'b00, 3'b000, CHAN};
            8'd2: emit_word = ts[15:0];
            8'd3: emit_word = ts[31:16];
            default: begin
                if (payload_idx < count) emit_word = payload_buf[payload_idx];
            end
        endcase
    end

    // Payload storage has no reset; only entries below count are ever read.
    always_ff @(posedge txclk) begin
        if (accept) payload_buf[count] <= bus.rx_databus;
    end

    // Counters, latched header fields and registered outputs.
    always_ff @(posedge txclk) begin
        if (reset) begin
            count             <= '0;
            idle_cnt          <= '0;
            w_idx             <= '0;
            len_bytes         <= '0;
            ts                <= '0;
            bus.fifo_wrreq    <= 1'b0;
            bus.fifo_data     <= '0;
            bus.rx_WR_enabled <= 1'b0;
            dropped_words     <= '0;
            busy              <= 1'b0;
        end else begin
            bus.fifo_wrreq    <= wr_d;
            bus.fifo_data     <= data_d;
            busy              <= (next_state == EMIT);
            bus.rx_WR_enabled <= (state == FILL) && (next_state == FILL) &&
                                 (count <= ENABLE_MAX);

            if (drop && (dropped_words != 8'hFF))
                dropped_words <= dropped_words + 8'd1;

            if (state == FILL) begin
                if (accept) count <= count + 8'd1;
                if (bus.rx_WR || !bus.rx_WR_done)
                    idle_cnt <= '0;
                else if (idle_cnt != IDLE_MAX)
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                if (next_state == EMIT) begin
                    len_bytes <= {1'b0, count, 1'b0};
                    ts        <= timestamp_clock;
                    w_idx     <= '0;
                end
            end else begin
                if (!bus.fifo_full) w_idx <= w_idx + 8'd1;
                if (next_state == FILL) begin
                    count    <= '0;
                    idle_cnt <= '0;
                end
            end
        end
    end
endmodule

// File: tb/tb_cmd_reply_packer.sv
// tb_cmd_reply_packer
//   Directed, table-driven bench for cmd_reply_packer. Each table row writes
//   a burst of reply words, checks the flush timing, captures the 256 FIFO
//   writes and compares them with a packet built from the row's inputs.
//   Hand-written sequences then cover overrun drops, a word arriving with a
//   full buffer, a long rx_WR_done=0 stall and a reset in the middle of EMIT.
module tb_cmd_reply_packer;
    logic        txclk = 1'b0;
    logic        reset;
    logic [31:0] timestamp_clock;
    logic [7:0]  dropped_words;
    logic        busy;
    bit          throttle_en;
    int          thr_cnt;
    int          errors;
    int          checks;
    logic [15:0] cap[$];

    cmd_reply_packer_if bus ();

    cmd_reply_packer dut (
        .txclk           (txclk),
        .reset           (reset),
        .timestamp_clock (timestamp_clock),
        .bus             (bus),
        .dropped_words   (dropped_words),
        .busy            (busy)
    );

    typedef struct {
        string       name;
        int          n;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [31:0] ts;
        bit          throttle;
        logic [15:0] exp_w0;
    } vec_t;

    vec_t vecs[5];

    always #5 txclk = ~txclk;

    // Capture every FIFO write shortly after the edge that produced it.
    always @(posedge txclk) begin
        #1;
        if (bus.fifo_wrreq) cap.push_back(bus.fifo_data);
    end

    // Backpressure generator: toggles fifo_full every 3 cycles when enabled.
    always @(negedge txclk) begin
        if (throttle_en) begin
            thr_cnt = thr_cnt + 1;
            if (thr_cnt == 3) begin
                bus.fifo_full = ~bus.fifo_full;
                thr_cnt = 0;
            end
        end else begin
            bus.fifo_full = 1'b0;
            thr_cnt = 0;
        end
    end

    function automatic logic [15:0] wordAt(int i, logic [15:0] d0, logic [15:0] d1);
        if (i == 0) return d0;
        if (i == 1) return d1;
        return 16'(i);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge txclk);
    endtask

    // Writes n reply words back-to-back, starting from a negedge.
    task automatic applyStimulus(input int n, input logic [15:0] d0, input logic [15:0] d1);
        for (int i = 0; i < n; i++) begin
            bus.rx_WR      = 1'b1;
            bus.rx_databus = wordAt(i, d0, d1);
            step(1);
            if (i >= 249)
                checkOutput($sformatf("wr_enabled_after_word%0d", i),
                            32'(bus.rx_WR_enabled), 32'(i <= 250));
        end
        bus.rx_WR      = 1'b0;
        bus.rx_databus = '0;
    endtask

    // Waits (bounded) for a whole packet past base, then checks no extra writes.
    task automatic waitPacket(input string tag, input int base);
        for (int c = 0; c < 3000 && (cap.size() - base) < 256; c++) step(1);
        step(4);
        checkOutput({tag, "_pkt_len"}, 32'(cap.size() - base), 32'd256);
    endtask

    task automatic comparePacket(input string tag, input int base, input int n,
                                 input logic [15:0] d0, input logic [15:0] d1,
                                 input logic [31:0] ts, input logic [15:0] exp_w0);
        logic [15:0] exp_w;
        for (int k = 0; k < 256; k++) begin
            if (k == 0)          exp_w = exp_w0;
            else if (k == 1)     exp_w = 16'h0C1F;
            else if (k == 2)     exp_w = ts[15:0];
            else if (k == 3)     exp_w = ts[31:16];
            else if (k - 4 < n)  exp_w = wordAt(k - 4, d0, d1);
            else                 exp_w = 16'h0000;
            if (base + k < cap.size())
                checkOutput($sformatf("%s_w%0d", tag, k), 32'(cap[base + k]), 32'(exp_w));
        end
    endtask

    // Checks busy rises exactly IDLE_TIMEOUT+1 edges after the last activity.
    task automatic checkTimeoutFlush(input string tag);
        step(16);
        checkOutput({tag, "_busy_before_timeout"}, 32'(busy), 32'd0);
        step(1);
        checkOutput({tag, "_busy_at_timeout"}, 32'(busy), 32'd1);
    endtask

    initial begin
        int base;
        bit early;
        errors          = 0;
        checks          = 0;
        throttle_en     = 1'b0;
        reset           = 1'b1;
        timestamp_clock = 32'h0;
        bus.rx_databus  = '0;
        bus.rx_WR       = 1'b0;
        bus.rx_WR_done  = 1'b1;

        vecs[0] = '{"ping",      2,   16'hBEEF, 16'h0102, 32'h1234_5678, 1'b0, 16'h0004};
        vecs[1] = '{"full",      252, 16'h0000, 16'h0001, 32'hCAFE_0001, 1'b0, 16'h01F8};
        vecs[2] = '{"full_thr",  252, 16'h0000, 16'h0001, 32'hCAFE_0001, 1'b1, 16'h01F8};
        vecs[3] = '{"single",    1,   16'hA5A5, 16'h0000, 32'h0BAD_F00D, 1'b1, 16'h0002};
        vecs[4] = '{"n251",      251, 16'h7E57, 16'h8001, 32'hFFFF_0000, 1'b0, 16'h01F6};

        step(3);
        checkOutput("rst_fifo_wrreq", 32'(bus.fifo_wrreq), 32'd0);
        checkOutput("rst_fifo_data", 32'(bus.fifo_data), 32'd0);
        checkOutput("rst_dropped", 32'(dropped_words), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wr_enabled", 32'(bus.rx_WR_enabled), 32'd0);
        reset = 1'b0;
        step(1);
        checkOutput("post_rst_wr_enabled", 32'(bus.rx_WR_enabled), 32'd1);

        for (int v = 0; v < 5; v++) begin
            base            = cap.size();
            timestamp_clock = vecs[v].ts;
            throttle_en     = vecs[v].throttle;
            applyStimulus(vecs[v].n, vecs[v].d0, vecs[v].d1);
            if (vecs[v].n == 252) begin
                checkOutput({vecs[v].name, "_busy_before_flushA"}, 32'(busy), 32'd0);
                step(1);
                checkOutput({vecs[v].name, "_busy_flushA"}, 32'(busy), 32'd1);
            end else begin
                checkTimeoutFlush(vecs[v].name);
            end
            waitPacket(vecs[v].name, base);
            throttle_en = 1'b0;
            comparePacket(vecs[v].name, base, vecs[v].n, vecs[v].d0, vecs[v].d1,
                          vecs[v].ts, vecs[v].exp_w0);
            checkOutput({vecs[v].name, "_busy_done"}, 32'(busy), 32'd0);
            checkOutput({vecs[v].name, "_wr_enabled_done"}, 32'(bus.rx_WR_enabled), 32'd1);
            step(3);
        end
        checkOutput("table_dropped", 32'(dropped_words), 32'd0);

        // Overrun: five words written while a packet is being emitted.
        base            = cap.size();
        timestamp_clock = 32'h0000_5555;
        applyStimulus(2, 16'h1111, 16'h2222);
        checkTimeoutFlush("ovr");
        step(3);
        bus.rx_WR      = 1'b1;
        bus.rx_databus = 16'hDEAD;
        step(5);
        bus.rx_WR      = 1'b0;
        bus.rx_databus = '0;
        checkOutput("ovr_dropped", 32'(dropped_words), 32'd5);
        waitPacket("ovr", base);
        comparePacket("ovr", base, 2, 16'h1111, 16'h2222, 32'h0000_5555, 16'h0004);
        step(2);
        base            = cap.size();
        timestamp_clock = 32'h0000_6666;
        applyStimulus(2, 16'h3333, 16'h4444);
        checkTimeoutFlush("ovr_next");
        waitPacket("ovr_next", base);
        comparePacket("ovr_next", base, 2, 16'h3333, 16'h4444, 32'h0000_6666, 16'h0004);
        checkOutput("ovr_next_dropped", 32'(dropped_words), 32'd5);
        step(2);

        // 253 words: the last one lands in the flush-A cycle and is dropped.
        base            = cap.size();
        timestamp_clock = 32'h0101_0202;
        applyStimulus(253, 16'h0000, 16'h0001);
        checkOutput("extra_busy", 32'(busy), 32'd1);
        checkOutput("extra_dropped", 32'(dropped_words), 32'd6);
        waitPacket("extra", base);
        comparePacket("extra", base, 252, 16'h0000, 16'h0001, 32'h0101_0202, 16'h01F8);
        step(2);

        // Command reader busy for 100 cycles: no timeout flush meanwhile.
        base            = cap.size();
        timestamp_clock = 32'h7777_8888;
        applyStimulus(2, 16'hABCD, 16'hEF01);
        bus.rx_WR_done = 1'b0;
        early          = 1'b0;
        for (int c = 0; c < 100; c++) begin
            step(1);
            if (busy) early = 1'b1;
        end
        checkOutput("stall_no_flush", 32'(early), 32'd0);
        bus.rx_WR_done = 1'b1;
        checkTimeoutFlush("stall");
        waitPacket("stall", base);
        comparePacket("stall", base, 2, 16'hABCD, 16'hEF01, 32'h7777_8888, 16'h0004);
        step(2);

        // Reset while word 100 of a packet is going out.
        base            = cap.size();
        timestamp_clock = 32'h0000_9999;
        applyStimulus(3, 16'h0A0A, 16'h0B0B);
        for (int c = 0; c < 600 && (cap.size() - base) < 101; c++) step(1);
        checkOutput("mid_rst_reached_w100", 32'(cap.size() - base >= 101), 32'd1);
        reset = 1'b1;
        step(1);
        checkOutput("mid_rst_wrreq", 32'(bus.fifo_wrreq), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_dropped", 32'(dropped_words), 32'd0);
        reset = 1'b0;
        base  = cap.size();
        step(20);
        checkOutput("mid_rst_no_stray_writes", 32'(cap.size() - base), 32'd0);
        timestamp_clock = 32'hAAAA_BBBB;
        applyStimulus(2, 16'hBEEF, 16'h0102);
        checkTimeoutFlush("after_rst");
        waitPacket("after_rst", base);
        comparePacket("after_rst", base, 2, 16'hBEEF, 16'h0102, 32'hAAAA_BBBB, 16'h0004);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
